pong_paddle_ctrl: RTL and testbench
===================================

Name: pong_paddle_ctrl

Overview:
Per-player paddle position source that feeds the `paddle1_vpos` / `paddle2_vpos` inputs of the pong core. It merges two control sources into one 8-bit vertical position: the analog stick (signed offset) and digital up/down buttons (keyboard or joystick, with frame-based acceleration). The wrapper instantiates it once per player in the `clk_sys` (7.159 MHz) domain, replacing the direct `analog + 8'h80` assignment.

Parameters:
CENTER, 8'h80, vpos after reset
POS_MIN, 8'd0, lowest allowed vpos (top)
POS_MAX, 8'd255, highest allowed vpos (bottom)
DEADZONE, 8, analog magnitude (unsigned) that must be exceeded to select analog mode
ACCEL_FRAMES, 4, frames held at one speed before speed increments
MAX_SPEED, 6, maximum vpos step per frame in digital mode

Ports:
clk_sys  in  1  system clock, 7.159 MHz
reset_n  in  1  asynchronous, active-low reset
vblank  in  1  pong vblank (clk_sys domain); rising edge is the frame tick
btn_up  in  1  digital up (level)
btn_down  in  1  digital down (level)
analog_y  in  8  signed two's-complement stick Y (joystick_analog[15:8])
vpos  out  8  paddle vertical position to the pong core
analog_mode  out  1  1 = vpos driven by the analog stick
moving  out  1  1 = digital motion active this frame

Behaviour:
- Reset (async, reset_n=0): vpos=CENTER, analog_mode=0, moving=0, FSM=IDLE, speed=1, hold counter=0, vblank edge register=0.
- Frame tick: tick = vblank & ~vblank_q (one-cycle pulse). Digital updates happen only on tick.
- Mode select (every cycle):
  - |analog_y| > DEADZONE, with magnitude computed at 9 bits so -128 gives 128, and no button pressed → analog_mode=1.
  - Any button pressed → analog_mode=0 on the next edge. Buttons win when both sources are active in the same cycle.
  - An analog value back inside the deadzone does not clear analog_mode.
- Analog mode: vpos <= clamp(analog_y + 8'h80, POS_MIN, POS_MAX), updated every clk_sys cycle, 1 cycle latency. FSM is forced to IDLE and speed to 1.
- Digital direction decode: dir_up = btn_up & ~btn_down; dir_dn = btn_down & ~btn_up. Both or neither pressed = no direction.
- FSM (digital mode, evaluated on tick):
  - IDLE: on dir_up go to UP; on dir_dn go to DN. On entry speed=1, hold=0, and vpos moves in the same tick.
  - UP: vpos <= max(vpos - speed, POS_MIN). Subtraction is done at 9 bits; no wrap.
  - DN: vpos <= min(vpos + speed, POS_MAX). Addition is done at 9 bits; no wrap.
  - Acceleration in UP/DN: hold increments each tick. When hold == ACCEL_FRAMES-1, hold=0 and speed = min(speed+1, MAX_SPEED).
  - Reversal (UP with dir_dn, or DN with dir_up): switch state and set speed=1, hold=0. The move uses the new direction with step 1.
  - No direction in UP/DN: go to IDLE with no move that tick; speed=1, hold=0.
- moving = 1 while FSM is UP or DN; it is registered and updated on tick.
- Between ticks, vpos holds in digital mode. Button changes between ticks take effect at the next tick, except the mode switch.
- Switching analog → digital: vpos keeps the last analog value and digital motion continues from there.

Test Plan:
- Reset with analog_y=0 and no buttons → vpos=0x80, analog_mode=0, moving=0. Holds across 10 ticks.
- btn_up held for 12 ticks, defaults → vpos per tick drops by 1,1,1,1,2,2,2,2,3,3,3,3. vpos=0x80-24=0x68, moving=1.
- btn_down held from vpos=0xFC → vpos reaches 0xFF, stays 0xFF with no wrap to 0x00; symmetric check with btn_up at 0x02 → 0x00.
- analog_y=0x05, then 0x20, then 0x80 (-128) → vpos unchanged/analog_mode=0, then 0xA0/analog_mode=1 one cycle later, then 0x00. Repeat with POS_MIN=8'h10 → 0x10.
- analog_y=0x40 with btn_down pressed in the same cycle → analog_mode=0, digital motion from the current vpos.
- btn_up held 8 ticks (speed 3), then btn_down → next tick step +1 downward. Both buttons pressed → FSM IDLE, moving=0, vpos frozen.
- reset_n asserted mid-motion between clock edges → vpos=0x80 and FSM=IDLE immediately without waiting for a clock edge.

Source files
------------

// File: rtl/pong_paddle_ctrl.sv
// Paddle vertical position source for one pong player: merges a signed analog
// stick with up/down buttons that accelerate the longer they are held.
module pong_paddle_ctrl #(
    parameter logic [7:0] CENTER       = 8'h80,
    parameter logic [7:0] POS_MIN      = 8'd0,
    parameter logic [7:0] POS_MAX      = 8'd255,
    parameter logic [7:0] DEADZONE     = 8'd8,
    parameter int         ACCEL_FRAMES = 4,
    parameter int         MAX_SPEED    = 6
) (
    input  logic       clk_sys,
    input  logic       reset_n,
    input  logic       vblank,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic [7:0] analog_y,
    output logic [7:0] vpos,
    output logic       analog_mode,
    output logic       moving
);

    typedef enum logic [1:0] {IDLE, UP, DN} state_t;

    state_t     state;
    state_t     dig_state;
    logic       vblank_q;
    logic       tick;
    logic [7:0] speed;
    logic [7:0] hold;

    logic signed [8:0] ana_s;
    logic        [8:0] ana_mag;
    logic signed [9:0] ana_pos;
    logic              any_btn;
    logic              mode_nxt;

    logic              dir_up;
    logic              dir_dn;
    logic        [7:0] spd_use;
    logic        [7:0] hold_base;
    logic signed [9:0] dig_sum;
    logic        [7:0] vpos_dig;
    logic        [7:0] speed_nxt;
    logic        [7:0] hold_nxt;

    // Wide signed intermediate keeps a 0->255 excursion from wrapping.
    function automatic logic [7:0] clamp_pos(input logic signed [9:0] v);
        if (v < $signed({2'b00, POS_MIN}))
            return POS_MIN;
        else if (v > $signed({2'b00, POS_MAX}))
            return POS_MAX;
        else
            return v[7:0];
    endfunction

    assign tick    = vblank & ~vblank_q;
    assign ana_s   = {analog_y[7], analog_y};
    assign ana_mag = ana_s[8] ? $unsigned(-ana_s) : $unsigned(ana_s);
    assign ana_pos = $signed({ana_s[8], ana_s}) + 10'sd128;
    assign any_btn = btn_up | btn_down;

    // Buttons always win; a stick drifting back into the deadzone keeps the mode.
    assign mode_nxt = ~any_btn & ((ana_mag > {1'b0, DEADZONE}) | analog_mode);

    always_comb begin
        dir_up    = btn_up & ~btn_down;
        dir_dn    = btn_down & ~btn_up;
        dig_state = dir_up ? UP : (dir_dn ? DN : IDLE);
        // Entering a direction (from IDLE or by reversal) restarts at step 1.
        spd_use   = (state == dig_state) ? speed : 8'd1;
        hold_base = (state == dig_state) ? hold  : 8'd0;
        if (dig_state == UP)
            dig_sum = $signed({2'b00, vpos}) - $signed({2'b00, spd_use});
        else
            dig_sum = $signed({2'b00, vpos}) + $signed({2'b00, spd_use});
        vpos_dig  = (dig_state == IDLE) ? vpos : clamp_pos(dig_sum);
        speed_nxt = spd_use;
        hold_nxt  = hold_base + 8'd1;
        if (dig_state == IDLE) begin
            speed_nxt = 8'd1;
            hold_nxt  = 8'd0;
        end else if (hold_base == 8'(ACCEL_FRAMES - 1)) begin
            hold_nxt  = 8'd0;
            speed_nxt = (spd_use >= 8'(MAX_SPEED)) ? 8'(MAX_SPEED) : spd_use + 8'd1;
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            vpos        <= CENTER;
            analog_mode <= 1'b0;
            moving      <= 1'b0;
            state       <= IDLE;
            speed       <= 8'd1;
            hold        <= 8'd0;
            vblank_q    <= 1'b0;
        end else begin
            vblank_q    <= vblank;
            analog_mode <= mode_nxt;
            if (mode_nxt) begin
                vpos   <= clamp_pos(ana_pos);
                state  <= IDLE;
                speed  <= 8'd1;
                hold   <= 8'd0;
                moving <= 1'b0;
            end else if (tick) begin
                vpos   <= vpos_dig;
                state  <= dig_state;
                speed  <= speed_nxt;
                hold   <= hold_nxt;
                moving <= (dig_state != IDLE);
            end
        end
    end

endmodule

// File: tb/tb_pong_paddle_ctrl.sv
// Bench for pong_paddle_ctrl: directed scenarios plus random stimulus against a
// frame-level behavioural model of the paddle.
module tb_pong_paddle_ctrl;

    localparam int ACCEL = 4;
    localparam int MAXS  = 6;
    localparam int DZ    = 8;
    localparam int PMIN  = 0;
    localparam int PMAX  = 255;

    logic       clk_sys  = 1'b0;
    logic       reset_n  = 1'b0;
    logic       vblank   = 1'b0;
    logic       btn_up   = 1'b0;
    logic       btn_down = 1'b0;
    logic [7:0] analog_y = 8'h00;
    logic [7:0] vpos, vpos2;
    logic       analog_mode, moving, mode2, moving2;

    int checks = 0;
    int errors = 0;

    int m_vpos, m_dir, m_speed, m_hold;
    bit m_mode, m_moving, m_vbq;

    pong_paddle_ctrl dut (
        .clk_sys(clk_sys), .reset_n(reset_n), .vblank(vblank),
        .btn_up(btn_up), .btn_down(btn_down), .analog_y(analog_y),
        .vpos(vpos), .analog_mode(analog_mode), .moving(moving)
    );

    pong_paddle_ctrl #(.POS_MIN(8'h10)) dut2 (
        .clk_sys(clk_sys), .reset_n(reset_n), .vblank(vblank),
        .btn_up(btn_up), .btn_down(btn_down), .analog_y(analog_y),
        .vpos(vpos2), .analog_mode(mode2), .moving(moving2)
    );

    always #5 clk_sys = ~clk_sys;

    function automatic int sval(input logic [7:0] x);
        return x[7] ? int'(x) - 256 : int'(x);
    endfunction

    function automatic int clampi(input int v);
        if (v < PMIN) return PMIN;
        if (v > PMAX) return PMAX;
        return v;
    endfunction

    task automatic model_reset();
        m_vpos = 128; m_dir = 0; m_speed = 1; m_hold = 0;
        m_mode = 0; m_moving = 0; m_vbq = 0;
    endtask

    // One clock edge of the paddle as seen by a player: mode choice, then
    // either follow the stick or take one frame step of digital motion.
    task automatic model_edge();
        bit tick;
        int a, mag, d;
        tick  = vblank && !m_vbq;
        m_vbq = vblank;
        a     = sval(analog_y);
        mag   = (a < 0) ? -a : a;
        if (btn_up || btn_down) m_mode = 0;
        else if (mag > DZ)      m_mode = 1;
        if (m_mode) begin
            m_vpos = clampi(a + 128);
            m_dir = 0; m_speed = 1; m_hold = 0; m_moving = 0;
        end else if (tick) begin
            d = (btn_up && !btn_down) ? -1 : ((btn_down && !btn_up) ? 1 : 0);
            if (d == 0) begin
                m_dir = 0; m_speed = 1; m_hold = 0;
            end else begin
                if (d != m_dir) begin
                    m_dir = d; m_speed = 1; m_hold = 0;
                end
                m_vpos = clampi(m_vpos + d * m_speed);
                if (m_hold == ACCEL - 1) begin
                    m_hold = 0;
                    if (m_speed < MAXS) m_speed++;
                end else begin
                    m_hold++;
                end
            end
            m_moving = (m_dir != 0);
        end
    endtask

    task automatic step();
        @(posedge clk_sys);
        if (reset_n) model_edge();
        #1;
    endtask

    task automatic tick_frame();
        vblank = 1'b1;
        step();
        vblank = 1'b0;
        step();
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_model(input string tag);
        chk({tag, "_vpos"}, vpos, 8'(m_vpos));
        chk({tag, "_mode"}, {7'd0, analog_mode}, {7'd0, m_mode});
        chk({tag, "_moving"}, {7'd0, moving}, {7'd0, m_moving});
    endtask

    initial begin
        int steps[12] = '{1, 1, 1, 1, 2, 2, 2, 2, 3, 3, 3, 3};
        logic [7:0] table_a[10] = '{8'h00, 8'h08, 8'h09, 8'hF8, 8'hF7,
                                    8'h80, 8'h7F, 8'h20, 8'hE0, 8'h05};
        int prev;

        model_reset();
        repeat (3) step();
        chk("rst_vpos", vpos, 8'h80);
        chk("rst_mode", {7'd0, analog_mode}, 8'h00);
        chk("rst_moving", {7'd0, moving}, 8'h00);
        reset_n = 1'b1;
        step();
        for (int i = 0; i < 10; i++) tick_frame();
        chk("idle_vpos", vpos, 8'h80);
        chk_model("idle");

        // Held up button: acceleration profile
        btn_up = 1'b1;
        prev = 128;
        for (int i = 0; i < 12; i++) begin
            tick_frame();
            prev = prev - steps[i];
            chk("up_accel", vpos, 8'(prev));
        end
        chk("up_final", vpos, 8'h68);
        chk("up_moving", {7'd0, moving}, 8'h01);
        chk_model("up");
        btn_up = 1'b0;
        tick_frame();
        chk("up_release_moving", {7'd0, moving}, 8'h00);

        // Bottom saturation from 0xFC
        analog_y = 8'h7C;
        step();
        chk("ana_fc", vpos, 8'hFC);
        chk("ana_fc_mode", {7'd0, analog_mode}, 8'h01);
        btn_down = 1'b1;
        step();
        chk("btn_wins_mode", {7'd0, analog_mode}, 8'h00);
        chk("btn_wins_vpos", vpos, 8'hFC);
        for (int i = 0; i < 6; i++) begin
            tick_frame();
            chk_model("dn_sat");
        end
        chk("dn_sat_ff", vpos, 8'hFF);
        btn_down = 1'b0;
        analog_y = 8'h00;
        tick_frame();

        // Top saturation from 0x02
        analog_y = 8'h82;
        step();
        chk("ana_02", vpos, 8'h02);
        btn_up = 1'b1;
        step();
        for (int i = 0; i < 5; i++) begin
            tick_frame();
            chk_model("up_sat");
        end
        chk("up_sat_00", vpos, 8'h00);
        btn_up = 1'b0;
        analog_y = 8'h00;
        tick_frame();

        // Deadzone and analog mapping
        analog_y = 8'h05;
        step();
        chk("dz_mode", {7'd0, analog_mode}, 8'h00);
        chk("dz_vpos", vpos, 8'h00);
        analog_y = 8'h08;
        step();
        chk("dz_edge_pos", {7'd0, analog_mode}, 8'h00);
        analog_y = 8'hF8;
        step();
        chk("dz_edge_neg", {7'd0, analog_mode}, 8'h00);
        analog_y = 8'h20;
        step();
        chk("ana_a0", vpos, 8'hA0);
        chk("ana_a0_mode", {7'd0, analog_mode}, 8'h01);
        analog_y = 8'h80;
        step();
        chk("ana_min", vpos, 8'h00);
        chk("ana_min_clamp", vpos2, 8'h10);
        chk("ana_min_mode2", {7'd0, mode2}, 8'h01);
        chk("ana_min_moving2", {7'd0, moving2}, 8'h00);
        analog_y = 8'h03;
        step();
        chk("dz_sticky_mode", {7'd0, analog_mode}, 8'h01);
        chk("dz_sticky_vpos", vpos, 8'h83);

        // Stick and button in the same cycle
        analog_y = 8'h40;
        btn_down = 1'b1;
        step();
        chk("both_src_mode", {7'd0, analog_mode}, 8'h00);
        chk("both_src_vpos", vpos, 8'h83);
        tick_frame();
        chk("both_src_move", vpos, 8'h84);
        chk("both_src_moving", {7'd0, moving}, 8'h01);
        btn_down = 1'b0;
        analog_y = 8'h00;
        tick_frame();
        chk_model("rel");

        // Reversal after reaching speed 3, then both buttons
        btn_up = 1'b1;
        for (int i = 0; i < 8; i++) tick_frame();
        chk("rev_pre", vpos, 8'h78);
        btn_up = 1'b0;
        btn_down = 1'b1;
        tick_frame();
        chk("rev_step1", vpos, 8'h79);
        btn_up = 1'b1;
        tick_frame();
        chk("both_btn_vpos", vpos, 8'h79);
        chk("both_btn_moving", {7'd0, moving}, 8'h00);
        tick_frame();
        chk("both_btn_frozen", vpos, 8'h79);
        chk_model("both");

        // Asynchronous reset between edges
        btn_up = 1'b0;
        tick_frame();
        tick_frame();
        chk("pre_rst_moving", {7'd0, moving}, 8'h01);
        #3;
        reset_n = 1'b0;
        #1;
        chk("async_vpos", vpos, 8'h80);
        chk("async_moving", {7'd0, moving}, 8'h00);
        chk("async_mode", {7'd0, analog_mode}, 8'h00);
        model_reset();
        step();
        reset_n = 1'b1;
        btn_down = 1'b0;
        step();
        chk_model("post_rst");

        // Random phase
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 7) == 0) btn_up = ~btn_up;
            if ($urandom_range(0, 7) == 0) btn_down = ~btn_down;
            if ($urandom_range(0, 11) == 0) analog_y = table_a[$urandom_range(0, 9)];
            vblank = ($urandom_range(0, 2) == 0);
            step();
            chk_model("rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
